// File: rtl/mem_arbiter_if.sv
// Memory-side bus of mem_arbiter: registered request/address/data from the arbiter,
// acknowledge and read data back from memory.
interface mem_arbiter_if;
  logic       mem_req;
  logic [7:0] addr;
  logic [7:0] data_out;
  logic       we;
  logic       mem_ready;
  logic [7:0] data_in;

  modport master (output mem_req, addr, data_out, we, input mem_ready, data_in);
  modport slave  (input mem_req, addr, data_out, we, output mem_ready, data_in);
endinterface

// File: rtl/mem_arbiter.sv
// Fetch/execute arbiter for a single 8-bit memory port, with a per-transaction watchdog.
// Define MEM_ARB_RR_EN for round-robin tie-breaking; otherwise exec has fixed priority.
module mem_arbiter #(
  parameter int TIMEOUT = 15
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 fetch_req,
  input  logic [7:0]           fetch_addr,
  output logic                 fetch_ready,
  input  logic                 exec_req,
  input  logic [7:0]           exec_addr,
  input  logic [7:0]           exec_data_out,
  input  logic                 exec_we,
  output logic                 exec_ready,
  output logic [7:0]           rdata,
  output logic                 err,
  output logic                 busy,
  output logic                 owner,
  mem_arbiter_if.master        mem
);

  typedef enum logic [1:0] {IDLE, WAIT, RELEASE} state_t;

  state_t     state;
  logic [7:0] cnt;
  logic       any_req;
  logic       grant_exec;
  logic       tmo_hit;
  logic       owner_req;

  always_comb begin
    any_req = fetch_req | exec_req;
`ifdef MEM_ARB_RR_EN
    // On a tie, hand the port to whoever did not have it last.
    grant_exec = exec_req & (~fetch_req | ~owner);
`else
    grant_exec = exec_req;
`endif
    tmo_hit   = (TIMEOUT != 0) && (({1'b0, cnt} + 9'd1) == 9'(TIMEOUT));
    owner_req = owner ? exec_req : fetch_req;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state        <= IDLE;
      cnt          <= 8'd0;
      mem.mem_req  <= 1'b0;
      mem.addr     <= 8'd0;
      mem.data_out <= 8'd0;
      mem.we       <= 1'b0;
      fetch_ready  <= 1'b0;
      exec_ready   <= 1'b0;
      rdata        <= 8'd0;
      err          <= 1'b0;
      busy         <= 1'b0;
      owner        <= 1'b1;
    end else begin
      case (state)
        IDLE: begin
          if (any_req) begin
            owner        <= grant_exec;
            mem.addr     <= grant_exec ? exec_addr : fetch_addr;
            mem.data_out <= grant_exec ? exec_data_out : 8'd0;
            mem.we       <= grant_exec & exec_we;
            mem.mem_req  <= 1'b1;
            busy         <= 1'b1;
            cnt          <= 8'd0;
            state        <= WAIT;
          end
        end
        WAIT: begin
          // An acknowledge on the watchdog's final cycle still counts as success.
          if (mem.mem_ready || tmo_hit) begin
            if (mem.mem_ready && !mem.we) rdata <= mem.data_in;
            err         <= ~mem.mem_ready;
            mem.mem_req <= 1'b0;
            mem.we      <= 1'b0;
            if (owner) exec_ready  <= 1'b1;
            else       fetch_ready <= 1'b1;
            state       <= RELEASE;
          end else begin
            cnt <= cnt + 8'd1;
          end
        end
        RELEASE: begin
          if (!owner_req) begin
            fetch_ready <= 1'b0;
            exec_ready  <= 1'b0;
            busy        <= 1'b0;
            state       <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Randomized scoreboard bench for mem_arbiter: a reference model predicts each grant
// and completion, a memory responder acknowledges, and a monitor checks the DUT.
module tb_mem_arbiter;
  localparam int TMO = 4;

  logic       clk = 1'b0;
  logic       rst;
  logic       fetch_req, exec_req, exec_we;
  logic [7:0] fetch_addr, exec_addr, exec_data_out;
  logic       fetch_ready, exec_ready, err, busy, owner;
  logic [7:0] rdata;

  mem_arbiter_if mif();

  mem_arbiter #(.TIMEOUT(TMO)) dut (
    .clk(clk), .rst(rst),
    .fetch_req(fetch_req), .fetch_addr(fetch_addr), .fetch_ready(fetch_ready),
    .exec_req(exec_req), .exec_addr(exec_addr), .exec_data_out(exec_data_out),
    .exec_we(exec_we), .exec_ready(exec_ready),
    .rdata(rdata), .err(err), .busy(busy), .owner(owner),
    .mem(mif)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit         own;
    logic [7:0] addr;
    bit         we;
    logic [7:0] wdata;
    int         lat;
    bit         err;
    logic [7:0] rdata;
  } txn_t;

  txn_t       exp_q[$];
  int         lat_q[$];
  int         total = 0;
  int         bad = 0;
  logic [7:0] ref_mem[256];
  logic [7:0] phys_mem[256];
  bit         ref_owner = 1'b1;
  logic [7:0] ref_rdata = 8'd0;
  bit         mon_en = 1'b0;
  bit         mem_en = 1'b0;
  bit         f_pend = 1'b0;
  bit         e_pend = 1'b0;

  task automatic chk1(input string name, input logic act, input logic exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0b expected=%0b at %0t", name, act, exp, $time);
    end
  endtask

  task automatic chk8(input string name, input logic [7:0] act, input logic [7:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%02h expected=%02h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic chki(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s actual=%0d expected=%0d at %0t", name, act, exp, $time);
    end
  endtask

  // Memory responder: acknowledges lat cycles after a request, unless the arbiter gave up.
  initial begin : responder
    int         l, k;
    logic [7:0] a, d;
    logic       w;
    mif.mem_ready = 1'b0;
    mif.data_in   = 8'd0;
    forever begin
      @(negedge clk);
      if (mem_en && mif.mem_req && lat_q.size() > 0) begin
        l = lat_q.pop_front();
        a = mif.addr; w = mif.we; d = mif.data_out; k = 0;
        while (k < l && mif.mem_req) begin
          @(negedge clk);
          k++;
        end
        if (mif.mem_req) begin
          mif.data_in = w ? 8'($urandom) : phys_mem[a];
          if (w) phys_mem[a] = d;
          mif.mem_ready = 1'b1;
          @(negedge clk);
          mif.mem_ready = 1'b0;
        end
      end
    end
  end

  // Monitor: checks grants, request length and completions against the scoreboard.
  initial begin : monitor
    logic p_req, p_fr, p_er;
    int   hi;
    int   exp_hi;
    txn_t t;
    p_req = 1'b0; p_fr = 1'b0; p_er = 1'b0; hi = 0;
    forever begin
      @(negedge clk);
      if (mon_en) begin
        if (mif.mem_req && !p_req) begin
          hi = 1;
          if (exp_q.size() == 0) begin
            total++; bad++;
            $display("FAIL unexpected_grant actual=mem_req expected=idle at %0t", $time);
          end else begin
            t = exp_q[0];
            chk1("grant_owner", owner, t.own);
            chk8("grant_addr", mif.addr, t.addr);
            chk1("grant_we", mif.we, t.we);
            if (t.we) chk8("grant_wdata", mif.data_out, t.wdata);
            chk1("grant_busy", busy, 1'b1);
          end
        end else if (mif.mem_req) begin
          hi++;
        end
        if (!mif.mem_req && p_req && exp_q.size() > 0) begin
          exp_hi = (exp_q[0].lat + 1 < TMO) ? exp_q[0].lat + 1 : TMO;
          chki("req_cycles", hi, exp_hi);
        end
        if ((fetch_ready && !p_fr) || (exec_ready && !p_er)) begin
          if (exp_q.size() == 0) begin
            total++; bad++;
            $display("FAIL unexpected_ready actual=ready expected=none at %0t", $time);
          end else begin
            t = exp_q.pop_front();
            chk1("ready_sel", exec_ready, t.own);
            chk1("ready_other", t.own ? fetch_ready : exec_ready, 1'b0);
            chk1("err", err, t.err);
            chk8("rdata", rdata, t.rdata);
            chk1("mem_req_low", mif.mem_req, 1'b0);
            chk1("we_low", mif.we, 1'b0);
          end
        end
      end
      p_req = mif.mem_req; p_fr = fetch_ready; p_er = exec_ready;
    end
  end

  // Raises requests, predicts the winner and its outcome, then releases the winner.
  task automatic round(input bit rf, input bit re, input logic [7:0] fa, input logic [7:0] ea,
                       input logic [7:0] ed, input bit ewe, input int lat);
    bit   win;
    txn_t t;
    int   c;
    if (rf && !f_pend) begin fetch_addr = fa; fetch_req = 1'b1; f_pend = 1'b1; end
    if (re && !e_pend) begin
      exec_addr = ea; exec_data_out = ed; exec_we = ewe; exec_req = 1'b1; e_pend = 1'b1;
    end
    if (!f_pend && !e_pend) begin fetch_addr = fa; fetch_req = 1'b1; f_pend = 1'b1; end
`ifdef MEM_ARB_RR_EN
    win = (f_pend && e_pend) ? !ref_owner : e_pend;
`else
    win = e_pend;
`endif
    t.own   = win;
    t.addr  = win ? exec_addr : fetch_addr;
    t.we    = win && exec_we;
    t.wdata = exec_data_out;
    t.lat   = lat;
    t.err   = (TMO != 0) && (lat >= TMO);
    if (!t.err && !t.we) ref_rdata = ref_mem[t.addr];
    if (!t.err && t.we)  ref_mem[t.addr] = t.wdata;
    t.rdata   = ref_rdata;
    ref_owner = win;
    exp_q.push_back(t);
    lat_q.push_back(lat);
    c = 0;
    while (!(win ? exec_ready : fetch_ready) && c < 60) begin
      @(negedge clk);
      c++;
    end
    chk1("ready_seen", win ? exec_ready : fetch_ready, 1'b1);
    repeat ($urandom_range(0, 2)) @(negedge clk);
    if (win) begin exec_req = 1'b0; e_pend = 1'b0; end
    else     begin fetch_req = 1'b0; f_pend = 1'b0; end
    @(negedge clk);
    chk1("ready_drop", win ? exec_ready : fetch_ready, 1'b0);
    chk1("busy_drop", busy, 1'b0);
  endtask

  initial begin : main
    logic [7:0] v;
    int         c;
    int         lat;
    rst = 1'b0;
    fetch_req = 1'b0; exec_req = 1'b0; exec_we = 1'b0;
    fetch_addr = 8'd0; exec_addr = 8'd0; exec_data_out = 8'd0;
    for (int i = 0; i < 256; i++) begin
      v = 8'($urandom);
      ref_mem[i] = v;
      phys_mem[i] = v;
    end
    ref_mem[8'h10] = 8'hA5;
    phys_mem[8'h10] = 8'hA5;
    repeat (2) @(negedge clk);

    chk1("rst_mem_req", mif.mem_req, 1'b0);
    chk8("rst_addr", mif.addr, 8'd0);
    chk8("rst_data_out", mif.data_out, 8'd0);
    chk1("rst_we", mif.we, 1'b0);
    chk1("rst_fetch_ready", fetch_ready, 1'b0);
    chk1("rst_exec_ready", exec_ready, 1'b0);
    chk8("rst_rdata", rdata, 8'd0);
    chk1("rst_err", err, 1'b0);
    chk1("rst_busy", busy, 1'b0);
    chk1("rst_owner", owner, 1'b1);

    rst = 1'b1; mon_en = 1'b1; mem_en = 1'b1;
    @(negedge clk);

    round(1'b1, 1'b0, 8'h10, 8'h00, 8'h00, 1'b0, 2);
    round(1'b0, 1'b1, 8'h00, 8'h3F, 8'h5A, 1'b1, 1);
    round(1'b1, 1'b1, 8'h20, 8'h21, 8'h77, 1'b0, 0);
    round(1'b1, 1'b1, 8'h22, 8'h23, 8'h78, 1'b1, 1);
    round(1'b0, 1'b1, 8'h00, 8'h40, 8'h00, 1'b0, 100);
    round(1'b1, 1'b0, 8'h3F, 8'h00, 8'h00, 1'b0, 0);
    round(1'b1, 1'b0, 8'h41, 8'h00, 8'h00, 1'b0, TMO - 1);
    round(1'b0, 1'b1, 8'h00, 8'h42, 8'h99, 1'b1, TMO - 1);

    for (int i = 0; i < 60; i++) begin
      lat = ($urandom_range(0, 7) == 0) ? int'($urandom_range(TMO, TMO + 3))
                                        : int'($urandom_range(0, TMO - 1));
      round(1'($urandom), 1'($urandom), 8'($urandom), 8'($urandom), 8'($urandom),
            1'($urandom), lat);
    end
    while (f_pend || e_pend)
      round(1'b0, 1'b0, 8'($urandom), 8'($urandom), 8'($urandom), 1'b0, 0);
    repeat (3) @(negedge clk);
    chki("scoreboard_drained", exp_q.size(), 0);

    // Reset in the middle of a wait: everything clears at once, no ready pulse.
    mon_en = 1'b0; mem_en = 1'b0;
    fetch_addr = 8'h55; fetch_req = 1'b1;
    c = 0;
    while (!mif.mem_req && c < 10) begin
      @(negedge clk);
      c++;
    end
    chk1("rstwait_grant", mif.mem_req, 1'b1);
    @(negedge clk);
    #2 rst = 1'b0;
    #1;
    chk1("arst_mem_req", mif.mem_req, 1'b0);
    chk8("arst_addr", mif.addr, 8'd0);
    chk1("arst_fetch_ready", fetch_ready, 1'b0);
    chk1("arst_busy", busy, 1'b0);
    chk1("arst_owner", owner, 1'b1);
    chk1("arst_err", err, 1'b0);
    chk8("arst_rdata", rdata, 8'd0);
    fetch_req = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    mif.data_in = 8'hEE;
    mif.mem_ready = 1'b1;
    @(negedge clk);
    mif.mem_ready = 1'b0;
    @(negedge clk);
    chk1("idle_ack_mem_req", mif.mem_req, 1'b0);
    chk1("idle_ack_fetch_ready", fetch_ready, 1'b0);
    chk1("idle_ack_exec_ready", exec_ready, 1'b0);
    chk8("idle_ack_rdata", rdata, 8'd0);
    chk1("idle_ack_busy", busy, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin : guard
    #400000;
    $display("FAIL global_timeout actual=running expected=finished");
    $fatal(1, "simulation did not finish");
  end

endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Two-requester arbiter that shares the CPU's single 8-bit memory port between the instruction-fetch stage and the execute stage. It sits between the pipeline stages and the external memory interface. It serialises requests with a four-phase req/ready handshake on each side and registers every memory-side output. A per-transaction watchdog aborts accesses that memory never acknowledges.

## Interface
Parameters:
- TIMEOUT, default 15: maximum cycles spent waiting for mem_ready before abort. Range 1..255; 0 disables the watchdog.

Ports:
- clk  in  1  system clock, all state on rising edge
- rst  in  1  asynchronous, active-low reset
- fetch_req  in  1  fetch read request; held until fetch_ready seen
- fetch_addr  in  8  fetch address; stable while fetch_req high
- fetch_ready  out  1  fetch transaction complete; held until fetch_req drops
- exec_req  in  1  execute request
- exec_addr  in  8  execute address; stable while exec_req high
- exec_data_out  in  8  execute write data
- exec_we  in  1  execute write enable (1 = store)
- exec_ready  out  1  execute transaction complete; held until exec_req drops
- rdata  out  8  read data of last completed read, valid while a ready is high
- err  out  1  last transaction timed out; valid while a ready is high
- busy  out  1  a transaction is in flight (state != IDLE)
- owner  out  1  current or last grant: 0 = fetch, 1 = exec
- mem_req  out  1  memory request
- addr  out  8  memory address
- data_out  out  8  memory write data
- we  out  1  memory write enable
- mem_ready  in  1  memory acknowledge
- data_in  in  8  memory read data, valid with mem_ready

## Operation
- States: IDLE, WAIT, RELEASE.
- IDLE: if neither req is high, stay. Otherwise select the winner (see Configuration). Latch its addr, write data and we (we forced 0 for fetch) into the memory-side registers. Set mem_req=1, owner=winner, clear the watchdog counter, then go to WAIT.
- WAIT: mem_req held at 1. Memory-side registers are frozen; requester-side changes are ignored. The watchdog counter increments each cycle.
  - On mem_ready=1: capture data_in into rdata if we=0 (rdata unchanged for writes), set mem_req=0, we=0, err=0, assert the owner's ready, and go to RELEASE.
  - If TIMEOUT!=0 and the counter reaches TIMEOUT with mem_ready low: set mem_req=0, we=0, err=1, leave rdata unchanged, assert the owner's ready, and go to RELEASE.
  - mem_ready and timeout in the same cycle: mem_ready wins, err=0.
- RELEASE: the owner's ready stays high. When the owner's req is sampled low, drop ready and go to IDLE. The non-owner's req has no effect in this state.
- mem_ready arriving in IDLE or RELEASE is ignored.
- Reset (asynchronous, any state): state=IDLE, mem_req=0, addr=0, data_out=0, we=0, fetch_ready=0, exec_ready=0, rdata=0, err=0, owner=1, counter=0. A transaction in flight is dropped with no ready pulse.

## Timing
- Request sampled high in IDLE at edge n: mem_req=1 and addr valid after edge n.
- mem_ready sampled high at edge m: ready=1, rdata valid and mem_req=0 after edge m.
- Owner's req sampled low at edge k: ready=0 and state=IDLE after edge k. The next grant is no earlier than edge k+1. The minimum transaction is 3 cycles with zero-wait memory.
- Timeout: with TIMEOUT=T, the abort happens at the T-th WAIT edge without mem_ready. mem_req is high for exactly T cycles.
- All outputs are registered; there is no combinational path from any input to any output.

## Configuration
- MEM_ARB_RR_EN defined: round-robin on ties. When both reqs are high in IDLE, grant goes to the requester that is not owner. After reset owner=1, so fetch wins the first tie.
- MEM_ARB_RR_EN undefined: fixed priority. Exec always wins ties; fetch is granted only when exec_req is low in IDLE.
- A single request is granted immediately in either mode.

## Test plan
- Fetch read, fetch_addr=8'h10, memory returns 8'hA5 with mem_ready 2 cycles after mem_req -> addr=8'h10, we=0, fetch_ready=1, rdata=8'hA5, err=0; fetch_ready drops the cycle after fetch_req drops.
- Exec store, exec_addr=8'h3F, exec_data_out=8'h5A, exec_we=1 -> mem_req=1, addr=8'h3F, data_out=8'h5A, we=1; exec_ready=1 after mem_ready; rdata unchanged.
- Both reqs asserted together twice in a row (each re-raised after release): with MEM_ARB_RR_EN -> fetch then exec; without it -> exec both times, fetch waits until exec_req is held low.
- TIMEOUT=4, mem_ready never asserted -> mem_req high exactly 4 cycles, then ready=1, err=1, rdata unchanged; a following transaction with mem_ready completes with err=0.
- rst pulled low mid-WAIT with mem_req=1 -> all outputs reset values immediately, no ready pulse; mem_ready asserted afterwards in IDLE is ignored.
- mem_ready and timeout coincide (mem_ready on the 4th WAIT cycle, TIMEOUT=4) -> err=0, rdata=data_in.
